fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It owns the PC and issues word requests to the instruction cache. Returned instructions and their NPC go into a small FIFO. The FIFO head drives the IF/DC pipeline latch inputs (imemload, npc). It handles redirects from the EX/MEM stages (branch, jump, jr), stalls, and HALT detection.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, FIFO entries (power of 2, 2..8)
HALT_OPCODE, 6'b111111, opcode field value (bits 31:26) that stops fetch

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
ihit  input  1  icache hit; iload is valid this cycle
iload  input  32  instruction word from icache
iREN  output  1  icache read request
iaddr  output  32  icache word address
pipe1_en  input  1  IF/DC latch enable; a valid head is consumed when this is 1
redirect_en  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch target, word-aligned
fetch_valid  output  1  FIFO head valid
imemload_o  output  32  head instruction; 32'h0 (NOP) when empty
npc_o  output  32  head PC+4; 32'h0 when empty
flushed1  output  1  pulses 1 for the cycle in which redirect_en is applied
halted  output  1  fetch stopped on HALT

Behaviour:
Interface: one clock, CLK. Reset RST is synchronous and active-high.

Reset values:
- PC = PC_INIT; FIFO empty; state = FETCH.
- fetch_valid = 0, imemload_o = 0, npc_o = 0, flushed1 = 0, halted = 0.
- iREN = 0 while RST = 1.

States:
- FETCH: issue requests.
- DRAIN: wait out an in-flight request that a redirect abandoned.
- HALTED: fetch stopped.

Cache contract:
- Once iREN rises, iaddr and iREN must stay stable until the cycle ihit = 1.

FETCH:
- iREN = (count < BUF_DEPTH); iaddr = PC.
- On ihit: push {iload, PC+4} into the FIFO and set PC = PC+4 (32-bit wrap at 32'hFFFF_FFFC allowed).
- If iload[31:26] == HALT_OPCODE: push the word, then go to HALTED. PC is not advanced.
- When the FIFO is full, iREN = 0. No request is pending in this case.

DRAIN:
- iREN = 1; iaddr = abandoned address, held in the internal reg pend_addr.
- On ihit: discard data, set PC = saved target, go to FETCH.

HALTED:
- iREN = 0; halted = 1.
- The FIFO still drains normally through pipe1_en.

redirect_en (highest priority; takes effect in any state):
- FIFO is cleared. A dequeue in the same cycle is suppressed. flushed1 = 1 for that cycle.
- If the state is FETCH, iREN = 1, and ihit = 0 (request pending): save redirect_pc, go to DRAIN.
- Otherwise (no pending request, or ihit = 1 this cycle): set PC = redirect_pc directly, go to FETCH, and discard the hit data.
- A redirect while in HALTED restarts fetch (wrong-path HALT).
- A redirect while in DRAIN replaces the saved target and stays in DRAIN.

FIFO:
- Push and pop may happen in the same cycle; count is unchanged and order is preserved.
- Pop occurs when fetch_valid & pipe1_en.
- Outputs come straight from the head entry (no extra register stage).

Latency:
- ihit in cycle N gives fetch_valid = 1 in N+1 if the FIFO was empty.
- The redirect target is requested in the cycle after the redirect; in DRAIN, in the cycle after the draining ihit.

RST asserted mid-DRAIN: the state returns to reset values immediately. The icache is reset by the same RST.

Optional Feature:
Macro FETCH_PERF_EN.

When defined, three added outputs:
- fetch_cnt [31:0]: counts words pushed.
- stall_cnt [31:0]: counts cycles with iREN = 1 and ihit = 0.
- flush_cnt [15:0]: counts redirects.

All three counters:
- reset to 0;
- saturate at all-ones;
- are frozen while halted.

When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then ihit = 1 every cycle, pipe1_en = 1, iload = 32'h2008_0001. Required: iaddr 0, 4, 8, ... on consecutive cycles; npc_o = 4 with fetch_valid = 1 one cycle after the first hit.
2. pipe1_en = 0 with ihit = 1 (BUF_DEPTH = 2). Required: two words pushed, then iREN = 0 and iaddr holds 8. Raise pipe1_en: iREN = 1 the next cycle, with order preserved.
3. Miss pending at iaddr 32'h10, redirect_en with redirect_pc = 32'h40. Required: flushed1 = 1; iaddr stays 32'h10 until ihit, and that data is dropped; next iaddr = 32'h40, and 32'h40's word is the first valid output.
4. Redirect in the same cycle as ihit at 32'h20, redirect_pc = 32'h100. Required: no DRAIN, next iaddr = 32'h100, FIFO empty.
5. iload = 32'hFC00_0000 at PC 32'h8. Required: HALT word output with npc_o = 32'hC; iREN = 0 afterwards; halted = 1. A later redirect to 32'h0 resumes fetch and clears halted.
6. Assert RST during DRAIN. Required: next cycle iaddr = PC_INIT, FIFO empty, all outputs at reset values. With FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from the icache and queues {instr, PC+4} for the IF/DC latch.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter int          BUF_DEPTH   = 2,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        pipe1_en,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] imemload_o,
    output logic [31:0] npc_o,
    output logic        flushed1,
    output logic        halted,
    output logic [1:0]  state_dbg
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic [31:0]      instr_mem [BUF_DEPTH];
    logic [31:0]      npc_mem   [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push, pop, flush, fifo_full, fifo_empty, is_halt;

    // Handshakes: icache side, iREN is the request and ihit completes it in the
    // cycle both are 1; consumer side, fetch_valid offers the head and pipe1_en
    // takes it in the cycle both are 1. A redirect overrides both sides.
    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == FULL_CNT);
        fetch_valid = !fifo_empty;
        imemload_o  = fifo_empty ? 32'h0 : instr_mem[rd_ptr_q];
        npc_o       = fifo_empty ? 32'h0 : npc_mem[rd_ptr_q];
        is_halt     = (iload[31:26] == HALT_OPCODE);
        flush       = redirect_en && !RST;
        flushed1    = flush;
        halted      = (state_q == S_HALTED);
        state_dbg   = state_q;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        iREN        = 1'b0;
        iaddr       = pc_q;
        push        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_FETCH: iREN = !fifo_full;
            S_DRAIN: begin
                iREN  = 1'b1;
                iaddr = pend_addr_q;
            end
            default: ;
        endcase
        if (RST) begin
            iREN = 1'b0;
        end

        if (flush) begin
            // While draining, pc_q already holds the redirect target.
            if (state_q == S_FETCH && iREN && !ihit) begin
                pend_addr_d = pc_q;
                pc_d        = redirect_pc;
                state_d     = S_DRAIN;
            end else if (state_q == S_DRAIN && !ihit) begin
                pc_d = redirect_pc;
            end else begin
                pc_d    = redirect_pc;
                state_d = S_FETCH;
            end
        end else begin
            pop = fetch_valid && pipe1_en;
            case (state_q)
                S_FETCH: begin
                    if (iREN && ihit) begin
                        push = 1'b1;
                        if (is_halt) begin
                            state_d = S_HALTED;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ihit) begin
                        state_d = S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_FETCH;
            pc_q        <= PC_INIT;
            pend_addr_q <= 32'h0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Payload storage needs no reset; validity is carried by count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= iload;
            npc_mem[wr_ptr_q]   <= pc_q + 32'd4;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
            flush_cnt <= 16'h0;
        end else if (state_q != S_HALTED) begin
            if (push && fetch_cnt != 32'hFFFF_FFFF) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (iREN && !ihit && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-during-drain sequence and random run against a queue model.
// Connects the counter ports when FETCH_PERF_EN is defined.
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] A     = 32'h2008_0001;
    localparam logic [31:0] HALTW = 32'hFC00_0000;

    logic        CLK = 1'b0;
    logic        RST, ihit, pipe1_en, redirect_en;
    logic [31:0] iload, redirect_pc;
    logic        iREN, fetch_valid, flushed1, halted;
    logic [31:0] iaddr, imemload_o, npc_o;
    logic [1:0]  state_dbg;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(
        .PC_INIT    (32'h0000_0000),
        .BUF_DEPTH  (DEPTH),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .iload      (iload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .pipe1_en   (pipe1_en),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid),
        .imemload_o (imemload_o),
        .npc_o      (npc_o),
        .flushed1   (flushed1),
        .halted     (halted),
        .state_dbg  (state_dbg)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, ih, input logic [31:0] il, input logic p1, rd,
                         input logic [31:0] rp);
        @(negedge CLK);
        RST = r; ihit = ih; iload = il; pipe1_en = p1; redirect_en = rd; redirect_pc = rp;
        #1;
    endtask

    typedef struct {
        logic        rst, ihit;
        logic [31:0] iload;
        logic        p1, rd;
        logic [31:0] rpc;
        logic        e_iren, c_addr;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_imem, e_npc;
        logic        e_fl, e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, ih, input logic [31:0] il, input logic p1, rd,
                       input logic [31:0] rp, input logic e_iren, c_addr,
                       input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_im, e_npc, input logic e_fl, e_h);
        vec_t v;
        v.rst = r; v.ihit = ih; v.iload = il; v.p1 = p1; v.rd = rd; v.rpc = rp;
        v.e_iren = e_iren; v.c_addr = c_addr; v.e_addr = e_addr; v.e_valid = e_v;
        v.e_imem = e_im; v.e_npc = e_npc; v.e_fl = e_fl; v.e_halt = e_h;
        vecs.push_back(v);
    endtask

    // Reference model: the buffer is a queue of {instr, npc}; modes are abstract.
    typedef enum {M_FETCH, M_DRAIN, M_HALT} mmode_t;
    mmode_t      m_mode;
    logic [31:0] m_pc, m_pend;
    logic [63:0] exp_q[$];
    logic [31:0] m_fc, m_sc;
    logic [15:0] m_flc;
    bit          m_known = 0;

    function automatic logic model_iren(input logic r);
        if (r) return 1'b0;
        if (m_mode == M_FETCH) return (exp_q.size() < DEPTH);
        if (m_mode == M_DRAIN) return 1'b1;
        return 1'b0;
    endfunction

    task automatic rand_step(input logic r, ih, input logic [31:0] il, input logic p1, rd,
                             input logic [31:0] rp);
        logic e_iren;
        e_iren = model_iren(r);
        drive(r, ih, il, p1, rd, rp);
        chk("rnd_iren", iREN, e_iren);
        chk("rnd_flushed1", flushed1, rd && !r);
        if (m_known) begin
            if (e_iren) chk("rnd_iaddr", iaddr, (m_mode == M_DRAIN) ? m_pend : m_pc);
            chk("rnd_valid", fetch_valid, exp_q.size() > 0);
            chk("rnd_imem", imemload_o, (exp_q.size() > 0) ? exp_q[0][63:32] : 32'h0);
            chk("rnd_npc", npc_o, (exp_q.size() > 0) ? exp_q[0][31:0] : 32'h0);
            chk("rnd_halted", halted, m_mode == M_HALT);
`ifdef FETCH_PERF_EN
            chk("rnd_fetch_cnt", fetch_cnt, m_fc);
            chk("rnd_stall_cnt", stall_cnt, m_sc);
            chk("rnd_flush_cnt", {16'h0, flush_cnt}, {16'h0, m_flc});
`endif
        end
        // Advance the model to the post-edge state.
        if (r) begin
            m_mode = M_FETCH; m_pc = 32'h0; m_pend = 32'h0; exp_q.delete();
            m_fc = 0; m_sc = 0; m_flc = 0; m_known = 1;
        end else begin
            if (m_mode != M_HALT) begin
                if (m_mode == M_FETCH && e_iren && ih && !rd && m_fc != 32'hFFFF_FFFF) m_fc++;
                if (e_iren && !ih && m_sc != 32'hFFFF_FFFF) m_sc++;
                if (rd && m_flc != 16'hFFFF) m_flc++;
            end
            if (rd) begin
                exp_q.delete();
                if (m_mode == M_FETCH && e_iren && !ih) begin
                    m_pend = m_pc; m_pc = rp; m_mode = M_DRAIN;
                end else if (m_mode == M_DRAIN && !ih) begin
                    m_pc = rp;
                end else begin
                    m_pc = rp; m_mode = M_FETCH;
                end
            end else begin
                if (exp_q.size() > 0 && p1) void'(exp_q.pop_front());
                if (m_mode == M_FETCH && e_iren && ih) begin
                    exp_q.push_back({il, m_pc + 32'd4});
                    if (il[31:26] == 6'b111111) m_mode = M_HALT;
                    else m_pc = m_pc + 32'd4;
                end else if (m_mode == M_DRAIN && ih) begin
                    m_mode = M_FETCH;
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; iload = 32'h0; pipe1_en = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'h0;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        // Streaming fetch with ihit every cycle.
        add(1,0,0,0,0,0,                  0,0,0,      0,0,0,                 0,0);
        add(0,1,A,1,0,0,                  1,1,0,      0,0,0,                 0,0);
        add(0,1,A,1,0,0,                  1,1,4,      1,A,4,                 0,0);
        add(0,1,A,1,0,0,                  1,1,8,      1,A,8,                 0,0);
        add(0,1,A,1,0,0,                  1,1,32'hC,  1,A,32'hC,             0,0);
        // Backpressure fills the buffer, then release.
        add(1,0,0,0,0,0,                  0,0,0,      1,A,32'h10,            0,0);
        add(0,1,32'h1111_0000,0,0,0,      1,1,0,      0,0,0,                 0,0);
        add(0,1,32'h1111_0001,0,0,0,      1,1,4,      1,32'h1111_0000,4,     0,0);
        add(0,0,0,0,0,0,                  0,1,8,      1,32'h1111_0000,4,     0,0);
        add(0,0,0,0,0,0,                  0,1,8,      1,32'h1111_0000,4,     0,0);
        add(0,0,0,1,0,0,                  0,1,8,      1,32'h1111_0000,4,     0,0);
        add(0,0,0,0,0,0,                  1,1,8,      1,32'h1111_0001,8,     0,0);
        add(0,1,32'h1111_0002,1,0,0,      1,1,8,      1,32'h1111_0001,8,     0,0);
        add(0,0,0,1,0,0,                  1,1,32'hC,  1,32'h1111_0002,32'hC, 0,0);
        add(0,0,0,0,0,0,                  1,1,32'hC,  0,0,0,                 0,0);
        // Redirect over a pending miss at 0x10.
        add(1,0,0,0,0,0,                  0,0,0,      0,0,0,                 0,0);
        add(0,1,32'h2222_0000,1,0,0,      1,1,0,      0,0,0,                 0,0);
        add(0,1,32'h2222_0001,1,0,0,      1,1,4,      1,32'h2222_0000,4,     0,0);
        add(0,1,32'h2222_0002,1,0,0,      1,1,8,      1,32'h2222_0001,8,     0,0);
        add(0,1,32'h2222_0003,1,0,0,      1,1,32'hC,  1,32'h2222_0002,32'hC, 0,0);
        add(0,0,0,0,0,0,                  1,1,32'h10, 1,32'h2222_0003,32'h10,0,0);
        add(0,0,0,1,1,32'h40,             1,1,32'h10, 1,32'h2222_0003,32'h10,1,0);
        add(0,0,0,1,0,0,                  1,1,32'h10, 0,0,0,                 0,0);
        add(0,1,32'hDEAD_BEEF,1,0,0,      1,1,32'h10, 0,0,0,                 0,0);
        add(0,1,32'h3333_0040,1,0,0,      1,1,32'h40, 0,0,0,                 0,0);
        add(0,0,0,1,0,0,                  1,1,32'h44, 1,32'h3333_0040,32'h44,0,0);
        // Redirect coinciding with a hit: no drain.
        add(1,0,0,0,0,0,                  0,0,0,      0,0,0,                 0,0);
        add(0,1,32'h4444_0000,1,1,32'h1C, 1,1,0,      0,0,0,                 1,0);
        add(0,1,32'h4444_001C,0,0,0,      1,1,32'h1C, 0,0,0,                 0,0);
        add(0,1,32'h4444_0020,0,1,32'h100,1,1,32'h20, 1,32'h4444_001C,32'h20,1,0);
        add(0,0,0,0,0,0,                  1,1,32'h100,0,0,0,                 0,0);
        add(0,1,32'h5555_0100,0,0,0,      1,1,32'h100,0,0,0,                 0,0);
        add(0,0,0,0,0,0,                  1,1,32'h104,1,32'h5555_0100,32'h104,0,0);
        // HALT at PC 0x8, then a redirect restarts fetch.
        add(1,0,0,0,0,0,                  0,0,0,      1,32'h5555_0100,32'h104,0,0);
        add(0,1,A,1,0,0,                  1,1,0,      0,0,0,                 0,0);
        add(0,1,A,1,0,0,                  1,1,4,      1,A,4,                 0,0);
        add(0,1,HALTW,1,0,0,              1,1,8,      1,A,8,                 0,0);
        add(0,0,0,0,0,0,                  0,0,0,      1,HALTW,32'hC,         0,1);
        add(0,0,0,1,0,0,                  0,0,0,      1,HALTW,32'hC,         0,1);
        add(0,0,0,0,0,0,                  0,0,0,      0,0,0,                 0,1);
        add(0,0,0,0,1,32'h0,              0,0,0,      0,0,0,                 1,1);
        add(0,0,0,0,0,0,                  1,1,0,      0,0,0,                 0,0);
        add(0,1,A,1,0,0,                  1,1,0,      0,0,0,                 0,0);
        add(0,0,0,1,0,0,                  1,1,4,      1,A,4,                 0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ihit, vecs[i].iload, vecs[i].p1, vecs[i].rd, vecs[i].rpc);
            chk($sformatf("vec%0d_iren", i), iREN, vecs[i].e_iren);
            if (vecs[i].c_addr) chk($sformatf("vec%0d_iaddr", i), iaddr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), fetch_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_imem", i), imemload_o, vecs[i].e_imem);
            chk($sformatf("vec%0d_npc", i), npc_o, vecs[i].e_npc);
            chk($sformatf("vec%0d_flushed1", i), flushed1, vecs[i].e_fl);
            chk($sformatf("vec%0d_halted", i), halted, vecs[i].e_halt);
        end

        // Reset asserted while draining an abandoned request.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, A, 0, 0, 0);
        chk("rd_first_iaddr", iaddr, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rd_miss_iaddr", iaddr, 32'h4);
        drive(0, 0, 0, 0, 1, 32'h40);
        chk("rd_flushed1", flushed1, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        chk("rd_drain_iren", iREN, 1'b1);
        chk("rd_drain_iaddr", iaddr, 32'h4);
        chk("rd_drain_valid", fetch_valid, 1'b0);
`ifdef FETCH_PERF_EN
        chk("rd_pre_fetch_cnt", fetch_cnt, 32'd1);
        chk("rd_pre_stall_cnt", stall_cnt, 32'd2);
        chk("rd_pre_flush_cnt", {16'h0, flush_cnt}, 32'd1);
`endif
        drive(1, 0, 0, 0, 0, 0);
        chk("rd_rst_iren", iREN, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rd_post_iaddr", iaddr, 32'h0);
        chk("rd_post_iren", iREN, 1'b1);
        chk("rd_post_valid", fetch_valid, 1'b0);
        chk("rd_post_imem", imemload_o, 32'h0);
        chk("rd_post_npc", npc_o, 32'h0);
        chk("rd_post_halted", halted, 1'b0);
`ifdef FETCH_PERF_EN
        chk("rd_post_fetch_cnt", fetch_cnt, 32'd0);
        chk("rd_post_stall_cnt", stall_cnt, 32'd0);
        chk("rd_post_flush_cnt", {16'h0, flush_cnt}, 32'd0);
`endif
        drive(0, 1, A, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rd_refetch_valid", fetch_valid, 1'b1);
        chk("rd_refetch_npc", npc_o, 32'h4);

        // Random traffic against the queue model.
        rand_step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r, ih, p1, rd, er;
            logic [31:0] il, rp;
            r  = ($urandom_range(0, 99) == 0);
            er = model_iren(r);
            ih = er && ($urandom_range(0, 2) != 0);
            il = ($urandom_range(0, 9) == 0) ? {6'b111111, 26'($urandom)} : $urandom;
            p1 = ($urandom_range(0, 3) != 0);
            rd = (m_mode == M_HALT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
            rp = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
            rand_step(r, ih, il, p1, rd, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
